// File: rtl/tt_bist_harness_if.sv
// ----------------------------------------------------------------------------
// tt_bist_harness_if
// Groups the BIST harness control, stimulus and result signals.
//   master : drives start/mode/seed/golden/resp_in, observes the results
//            (the controller or testbench side).
//   slave  : the harness itself.
// Signals:
//   start      - one-cycle run request
//   mode       - stimulus mode (00 LFSR, 01 counter, 10 walking-one, 11 constant)
//   seed       - LFSR seed, or the constant vector in mode 11
//   golden     - expected final signature
//   resp_in    - response from the device under test
//   stim_out   - stimulus vector to the device under test
//   stim_valid - stim_out carries a counted vector this cycle
//   busy       - run in progress
//   done       - run complete, result valid
//   pass       - signature matched golden (valid while done=1)
//   signature  - current MISR contents
// ----------------------------------------------------------------------------
interface tt_bist_harness_if #(
    parameter int WIDTH = 8,
    parameter int SIG_W = 16
);
    logic             start;
    logic [1:0]       mode;
    logic [WIDTH-1:0] seed;
    logic [SIG_W-1:0] golden;
    logic [WIDTH-1:0] resp_in;
    logic [WIDTH-1:0] stim_out;
    logic             stim_valid;
    logic             busy;
    logic             done;
    logic             pass;
    logic [SIG_W-1:0] signature;

    modport master (
        output start, mode, seed, golden, resp_in,
        input  stim_out, stim_valid, busy, done, pass, signature
    );

    modport slave (
        input  start, mode, seed, golden, resp_in,
        output stim_out, stim_valid, busy, done, pass, signature
    );
endinterface

// File: rtl/tt_bist_harness.sv
// ----------------------------------------------------------------------------
// tt_bist_harness
// Built-in self-test harness: generates PATTERNS stimulus vectors (LFSR,
// counter, walking-one or constant), compresses the device responses that
// arrive LATENCY cycles later into a MISR signature and compares the final
// signature with a golden value.
// Ports:
//   clk - single clock, rising edge
//   rst - asynchronous active-high reset
//   bus - tt_bist_harness_if.slave (start/mode/seed/golden/resp_in in,
//         stim_out/stim_valid/busy/done/pass/signature out)
// ----------------------------------------------------------------------------
module tt_bist_harness #(
    parameter int               WIDTH     = 8,
    parameter int               SIG_W     = 16,
    parameter int               PATTERNS  = 256,
    parameter int               LATENCY   = 1,
    parameter logic [WIDTH-1:0] LFSR_POLY = WIDTH'(8'hB8),
    parameter logic [SIG_W-1:0] MISR_POLY = SIG_W'(16'h1021)
) (
    input  logic              clk,
    input  logic              rst,
    tt_bist_harness_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [15:0] LAST_CNT   = 16'(PATTERNS - 1);
    localparam logic [2:0]  LAST_DRAIN = (LATENCY > 0) ? 3'(LATENCY - 1) : 3'd0;

    state_t           state_q, state_d;
    logic [1:0]       mode_q, mode_d;
    logic [WIDTH-1:0] vec_q, vec_d;
    logic [15:0]      cnt_q, cnt_d;
    logic [2:0]       drain_q, drain_d;
    logic [SIG_W-1:0] sig_q, sig_d;
    logic             pass_q, pass_d;
    logic             in_run;
    logic             capture;
    logic [SIG_W-1:0] misr_next;

    // First vector of a run, computed from the inputs seen alongside start.
    // The latched seed lives on in vec_q (constant mode simply never advances it).
    function automatic logic [WIDTH-1:0] first_vec(input logic [1:0] md,
                                                   input logic [WIDTH-1:0] sd);
        case (md)
            2'b00:   first_vec = (sd == '0) ? WIDTH'(1) : sd;  // avoid LFSR lock-up
            2'b01:   first_vec = '0;
            2'b10:   first_vec = WIDTH'(1);
            default: first_vec = sd;
        endcase
    endfunction

    function automatic logic [WIDTH-1:0] next_vec(input logic [1:0] md,
                                                  input logic [WIDTH-1:0] v);
        case (md)
            2'b00:   next_vec = v[0] ? ((v >> 1) ^ LFSR_POLY) : (v >> 1);
            2'b01:   next_vec = v + WIDTH'(1);
            2'b10:   next_vec = {v[WIDTH-2:0], v[WIDTH-1]};  // rotate wraps to bit 0
            default: next_vec = v;
        endcase
    endfunction

    assign in_run         = (state_q == RUN);
    assign bus.stim_out   = in_run ? vec_q : '0;
    assign bus.stim_valid = in_run;
    assign bus.busy       = (state_q == RUN) || (state_q == DRAIN);
    assign bus.done       = (state_q == DONE);
    assign bus.pass       = pass_q;
    assign bus.signature  = sig_q;

    // Capture qualifier: stim_valid delayed by the response latency so that
    // exactly one capture lines up with each emitted vector.
    generate
        if (LATENCY == 0) begin : g_direct
            assign capture = in_run;
        end else begin : g_pipe
            logic [LATENCY-1:0] vpipe_q;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    vpipe_q <= '0;
                end else begin
                    vpipe_q <= LATENCY'({vpipe_q, in_run});
                end
            end
            assign capture = vpipe_q[LATENCY-1];
        end
    endgenerate

    assign misr_next = {sig_q[SIG_W-2:0], 1'b0}
                     ^ (sig_q[SIG_W-1] ? MISR_POLY : '0)
                     ^ SIG_W'(bus.resp_in);

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        vec_d   = vec_q;
        cnt_d   = cnt_q;
        drain_d = drain_q;
        pass_d  = pass_q;
        sig_d   = capture ? misr_next : sig_q;

        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_d = RUN;
                    mode_d  = bus.mode;
                    vec_d   = first_vec(bus.mode, bus.seed);
                    cnt_d   = '0;
                    sig_d   = '0;
                    pass_d  = 1'b0;
                end
            end
            RUN: begin
                vec_d = next_vec(mode_q, vec_q);
                cnt_d = cnt_q + 16'd1;
                if (cnt_q == LAST_CNT) begin
                    if (LATENCY > 0) begin
                        state_d = DRAIN;
                        drain_d = '0;
                    end else begin
                        // sig_d already holds the final capture of this edge
                        state_d = DONE;
                        pass_d  = (sig_d == bus.golden);
                    end
                end
            end
            DRAIN: begin
                drain_d = drain_q + 3'd1;
                if (drain_q == LAST_DRAIN) begin
                    state_d = DONE;
                    pass_d  = (sig_d == bus.golden);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            mode_q  <= '0;
            vec_q   <= '0;
            cnt_q   <= '0;
            drain_q <= '0;
            sig_q   <= '0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            vec_q   <= vec_d;
            cnt_q   <= cnt_d;
            drain_q <= drain_d;
            sig_q   <= sig_d;
            pass_q  <= pass_d;
        end
    end

endmodule

// File: doc/tt_bist_harness.md
TT_BIST_HARNESS -- requirements
Module: tt_bist_harness

Interface
REQ-001 The block SHALL provide parameter WIDTH, default 8, meaning the stimulus and response vector width (2..16).
REQ-002 The block SHALL provide parameter SIG_W, default 16, meaning the signature register width (SIG_W >= WIDTH).
REQ-003 The block SHALL provide parameter PATTERNS, default 256, meaning the number of vectors per run (1..65535).
REQ-004 The block SHALL provide parameter LATENCY, default 1, meaning the DUT response delay in cycles (0..7).
REQ-005 The block SHALL provide parameter LFSR_POLY, default 8'hB8, meaning the Galois tap mask for stimulus generation, WIDTH bits.
REQ-006 The block SHALL provide parameter MISR_POLY, default 16'h1021, meaning the signature feedback mask, SIG_W bits.
REQ-007 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-008 clk  input  1  single clock; all state updates on the rising edge.
REQ-009 rst  input  1  asynchronous, active-high reset.
REQ-010 start  input  1  one-cycle run request.
REQ-011 mode  input  2  stimulus mode: 00 LFSR, 01 counter, 10 walking-one, 11 constant.
REQ-012 seed  input  WIDTH  initial LFSR state, or the constant value in mode 11.
REQ-013 golden  input  SIG_W  expected final signature.
REQ-014 resp_in  input  WIDTH  DUT response, sampled LATENCY cycles after the matching stimulus.
REQ-015 stim_out  output  WIDTH  stimulus vector to the DUT.
REQ-016 stim_valid  output  1  stim_out carries a counted vector this cycle.
REQ-017 busy  output  1  run in progress.
REQ-018 done  output  1  run complete; result valid.
REQ-019 pass  output  1  signature equals golden; valid only while done=1.
REQ-020 signature  output  SIG_W  current MISR contents.

Function
REQ-021 The FSM SHALL have states IDLE, RUN, DRAIN and DONE.
REQ-022 The FSM SHALL move from IDLE or DONE to RUN on start=1, latching mode and seed, clearing the signature to 0 and the pattern count to 0, and deasserting done and pass.
REQ-023 start SHALL be ignored while in RUN or DRAIN.
REQ-024 In RUN, stim_valid SHALL be 1 every cycle, with exactly PATTERNS vectors emitted on consecutive cycles, the first in the cycle after start.
REQ-025 RUN SHALL go to DRAIN after the last vector when LATENCY>0, and directly to DONE when LATENCY=0.
REQ-026 DRAIN SHALL last exactly LATENCY cycles and then go to DONE.
REQ-027 busy SHALL equal 1 in RUN and DRAIN only.
REQ-028 DONE SHALL hold done=1 and freeze signature until the next start.
REQ-029 In LFSR mode (00), vector 0 SHALL be the latched seed, with next = (s>>1) XOR (s[0] ? LFSR_POLY : 0).
REQ-030 In LFSR mode, a seed of 0 SHALL be replaced by 1 so the generator never locks up.
REQ-031 In counter mode (01), vectors SHALL be 0, 1, 2, ..., wrapping modulo 2^WIDTH.
REQ-032 In walking-one mode (10), vectors SHALL be 1, 2, 4, ..., wrapping to 1 after bit WIDTH-1.
REQ-033 In constant mode (11), every vector SHALL equal the latched seed.
REQ-034 Outside RUN, stim_out SHALL hold 0 and stim_valid SHALL be 0.
REQ-035 A LATENCY-deep shift register of stim_valid SHALL qualify capture; with LATENCY=0, capture SHALL be qualified by stim_valid directly.
REQ-036 On each qualified cycle, the signature SHALL update as sig = (sig<<1, truncated to SIG_W) XOR (sig[SIG_W-1] ? MISR_POLY : 0) XOR zero-extended resp_in.
REQ-037 Exactly PATTERNS captures SHALL occur per run.
REQ-038 pass SHALL be registered on entry to DONE as (signature == golden).

Reset
REQ-039 Asserting rst SHALL immediately force IDLE, with stim_out=0, stim_valid=0, busy=0, done=0, pass=0, signature=0, the pattern count cleared and the capture pipeline cleared.
REQ-040 rst asserted mid-RUN or mid-DRAIN SHALL abort the run with no done pulse.
REQ-041 The first start after rst deasserts SHALL be honoured.

Verification
REQ-042 Counter mode, PATTERNS=4, LATENCY=1, resp_in=0, golden=0 -> stim_out 0,1,2,3 with stim_valid high 4 cycles, 1 DRAIN cycle, then done=1, signature=0x0000, pass=1.
REQ-043 LFSR mode, seed=8'h01, WIDTH=8 -> stim_out 01, B8, 5C, 2E on the first four cycles.
REQ-044 seed=0 in LFSR mode -> first vector 01.
REQ-045 Walking-one, WIDTH=8, PATTERNS=10 -> vectors 01, 02, 04, ..., 80, 01, 02.
REQ-046 PATTERNS=2, LATENCY=0, resp_in=1 constant, golden=0x0003 -> signature 0x0001 then 0x0003, pass=1; the same run with golden=0x0004 -> pass=0.
REQ-047 start pulsed mid-RUN -> ignored, with PATTERNS unchanged.
REQ-048 rst pulsed at vector 2 -> all outputs 0 immediately, and a new start runs the full sequence from vector 0.
